// File: rtl/reorder_buffer.sv
// In-order reorder buffer: grants tags at issue, captures CDB results, retires one entry per cycle to the register file.
// Commit is registered one edge after the head becomes ready; allocation stalls via rob_full while full or flushing.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_AW    = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,
    output logic [ROB_AW-1:0] alloc_rob_num,
    output logic              rob_full,
    input  logic              wb_valid,
    input  logic [ROB_AW-1:0] wb_rob_num,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_misbranch,
    input  logic [DATA_W-1:0] wb_target,
    input  logic [ROB_AW-1:0] query1_rob_num,
    input  logic [ROB_AW-1:0] query2_rob_num,
    output logic              query1_ready,
    output logic              query2_ready,
    output logic [DATA_W-1:0] query1_data,
    output logic [DATA_W-1:0] query2_data,
    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [ROB_AW-1:0] commit_rob_num,
    output logic              has_misbranch,
    output logic [DATA_W-1:0] redirect_pc
);

    localparam logic [ROB_AW:0]   FULL_COUNT = (ROB_AW+1)'(ROB_DEPTH);
    localparam logic [ROB_AW:0]   CNT_ONE    = (ROB_AW+1)'(1);
    localparam logic [ROB_AW-1:0] PTR_ONE    = ROB_AW'(1);

    logic [ROB_DEPTH-1:0] ent_valid;
    logic [ROB_DEPTH-1:0] ent_ready;
    logic [ROB_DEPTH-1:0] ent_misb;
    logic [4:0]           ent_rd     [ROB_DEPTH];
    logic [DATA_W-1:0]    ent_data   [ROB_DEPTH];
    logic [DATA_W-1:0]    ent_target [ROB_DEPTH];

    logic [ROB_AW-1:0] head;
    logic [ROB_AW-1:0] tail;
    logic [ROB_AW:0]   count;
    logic              flush_pending;

    logic do_alloc;
    logic do_wb;
    logic do_commit;

    // Full uses the pre-edge count, so a same-cycle commit never frees a slot for allocation.
    assign rob_full      = (count == FULL_COUNT) | flush_pending;
    assign alloc_rob_num = tail;
    assign do_alloc      = alloc_valid & ~rob_full;
    assign do_wb         = wb_valid & ent_valid[wb_rob_num];
    assign do_commit     = ent_valid[head] & ent_ready[head] & ~flush_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_valid      <= '0;
            ent_ready      <= '0;
            ent_misb       <= '0;
            flush_pending  <= 1'b0;
            commit_valid   <= 1'b0;
            commit_rd      <= '0;
            commit_data    <= '0;
            commit_rob_num <= '0;
            has_misbranch  <= 1'b0;
            redirect_pc    <= '0;
        end else if (!rdy) begin
            commit_valid  <= 1'b0;
            has_misbranch <= 1'b0;
        end else if (flush_pending) begin
            // Everything younger than the mispredicted branch is squashed here.
            has_misbranch <= 1'b1;
            commit_valid  <= 1'b0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_ready     <= '0;
            ent_misb      <= '0;
            flush_pending <= 1'b0;
        end else begin
            has_misbranch <= 1'b0;
            commit_valid  <= do_commit;
            if (do_wb) begin
                ent_ready[wb_rob_num] <= 1'b1;
                ent_misb[wb_rob_num]  <= wb_misbranch;
            end
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_ready[tail] <= 1'b0;
                ent_misb[tail]  <= 1'b0;
                tail            <= tail + PTR_ONE;
            end
            if (do_commit) begin
                commit_rd       <= ent_rd[head];
                commit_data     <= ent_data[head];
                commit_rob_num  <= head;
                ent_valid[head] <= 1'b0;
                ent_ready[head] <= 1'b0;
                head            <= head + PTR_ONE;
                if (ent_misb[head]) begin
                    flush_pending <= 1'b1;
                    redirect_pc   <= ent_target[head];
                end
            end
            if (do_alloc && !do_commit) begin
                count <= count + CNT_ONE;
            end else if (!do_alloc && do_commit) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Payload storage needs no reset: it is only read behind valid/ready.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush_pending) begin
            if (do_wb) begin
                ent_data[wb_rob_num]   <= wb_data;
                ent_target[wb_rob_num] <= wb_target;
            end
            if (do_alloc) begin
                ent_rd[tail] <= alloc_rd;
            end
        end
    end

    always_comb begin
        query1_ready = 1'b0;
        query1_data  = '0;
        if (wb_valid && (wb_rob_num == query1_rob_num)) begin
            query1_ready = 1'b1;
            query1_data  = wb_data;
        end else if (ent_valid[query1_rob_num] && ent_ready[query1_rob_num]) begin
            query1_ready = 1'b1;
            query1_data  = ent_data[query1_rob_num];
        end
    end

    always_comb begin
        query2_ready = 1'b0;
        query2_data  = '0;
        if (wb_valid && (wb_rob_num == query2_rob_num)) begin
            query2_ready = 1'b1;
            query2_data  = wb_data;
        end else if (ent_valid[query2_rob_num] && ent_ready[query2_rob_num]) begin
            query2_ready = 1'b1;
            query2_data  = ent_data[query2_rob_num];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; retirements are matched against a queue of expected commits.
module tb_reorder_buffer;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } commit_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_rob_num;
    logic        rob_full;
    logic        wb_valid;
    logic [3:0]  wb_rob_num;
    logic [31:0] wb_data;
    logic        wb_misbranch;
    logic [31:0] wb_target;
    logic [3:0]  query1_rob_num;
    logic [3:0]  query2_rob_num;
    logic        query1_ready;
    logic        query2_ready;
    logic [31:0] query1_data;
    logic [31:0] query2_data;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [3:0]  commit_rob_num;
    logic        has_misbranch;
    logic [31:0] redirect_pc;

    int      checks = 0;
    int      errors = 0;
    commit_t exp_q[$];

    reorder_buffer #(.ROB_DEPTH(16), .ROB_AW(4), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_rob_num  (alloc_rob_num),
        .rob_full       (rob_full),
        .wb_valid       (wb_valid),
        .wb_rob_num     (wb_rob_num),
        .wb_data        (wb_data),
        .wb_misbranch   (wb_misbranch),
        .wb_target      (wb_target),
        .query1_rob_num (query1_rob_num),
        .query2_rob_num (query2_rob_num),
        .query1_ready   (query1_ready),
        .query2_ready   (query2_ready),
        .query1_data    (query1_data),
        .query2_data    (query2_data),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_data    (commit_data),
        .commit_rob_num (commit_rob_num),
        .has_misbranch  (has_misbranch),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid  = 1'b0;
        wb_valid     = 1'b0;
        wb_misbranch = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] d, input logic mb, input logic [31:0] tgt);
        wb_valid     = 1'b1;
        wb_rob_num   = tag;
        wb_data      = d;
        wb_misbranch = mb;
        wb_target    = tgt;
    endtask

    task automatic expect_commit(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] d);
        commit_t c;
        c.tag  = tag;
        c.rd   = rd;
        c.data = d;
        exp_q.push_back(c);
    endtask

    // Retirement monitor: every commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        commit_t got;
        commit_t want;
        if (commit_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_commit: observed tag %0d expected no commit", commit_rob_num);
            end
            if (exp_q.size() != 0) begin
                got.tag  = commit_rob_num;
                got.rd   = commit_rd;
                got.data = commit_data;
                want     = exp_q.pop_front();
                check("commit_tuple", 64'(got), 64'(want));
            end
        end
        if (has_misbranch === 1'b1) begin
            check("flush_excludes_commit", 64'(commit_valid), 64'(0));
        end
    end

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        alloc_rd       = '0;
        wb_rob_num     = '0;
        wb_data        = '0;
        wb_target      = '0;
        query1_rob_num = '0;
        query2_rob_num = '0;
        idle();
        tick();
        tick();
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_has_misbranch", 64'(has_misbranch), 64'(0));
        check("rst_rob_full", 64'(rob_full), 64'(0));
        check("rst_alloc_rob_num", 64'(alloc_rob_num), 64'(0));
        check("rst_redirect_pc", 64'(redirect_pc), 64'(0));
        check("rst_commit_rd", 64'(commit_rd), 64'(0));
        check("rst_commit_data", 64'(commit_data), 64'(0));
        check("rst_commit_rob_num", 64'(commit_rob_num), 64'(0));
        rst = 1'b0;

        // Out-of-order writebacks retire in tag order.
        for (int i = 0; i < 3; i++) begin
            do_alloc(5'(i + 1));
            check("t1_alloc_tag", 64'(alloc_rob_num), 64'(i));
            expect_commit(4'(i), 5'(i + 1), 32'(i * 17));
            tick();
        end
        idle();
        do_wb(4'd2, 32'h22, 1'b0, 32'h0);
        tick();
        do_wb(4'd0, 32'h00, 1'b0, 32'h0);
        tick();
        do_wb(4'd1, 32'h11, 1'b0, 32'h0);
        tick();
        check("t1_commit0", 64'(commit_valid), 64'(1));
        idle();
        tick();
        check("t1_commit1", 64'(commit_valid), 64'(1));
        tick();
        check("t1_commit2", 64'(commit_valid), 64'(1));
        tick();
        check("t1_drained", 64'(commit_valid), 64'(0));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // Fill all 16 entries (tail wraps from 15 to 0) starting at tag 3.
        for (int i = 0; i < 16; i++) begin
            do_alloc(5'(i + 1));
            check("t2_alloc_tag", 64'(alloc_rob_num), 64'((3 + i) % 16));
            tick();
        end
        do_alloc(5'd17);
        check("t2_full", 64'(rob_full), 64'(1));
        tick();
        check("t2_17th_ignored", 64'(alloc_rob_num), 64'(3));
        check("t2_still_full", 64'(rob_full), 64'(1));
        idle();
        do_wb(4'd3, 32'h33, 1'b0, 32'h0);
        expect_commit(4'd3, 5'd1, 32'h33);
        tick();
        idle();
        do_alloc(5'd20);
        check("t2_full_at_commit", 64'(rob_full), 64'(1));
        tick();
        check("t2_commit_head", 64'(commit_valid), 64'(1));
        check("t2_alloc_blocked", 64'(alloc_rob_num), 64'(3));
        check("t2_slot_free", 64'(rob_full), 64'(0));
        tick();
        idle();
        check("t2_regrant_tail", 64'(alloc_rob_num), 64'(4));
        check("t2_refull", 64'(rob_full), 64'(1));

        // Mispredicted branch at tag 4 with younger tags 5-7 already complete.
        do_wb(4'd5, 32'h55, 1'b0, 32'h0);
        tick();
        do_wb(4'd6, 32'h66, 1'b0, 32'h0);
        tick();
        do_wb(4'd7, 32'h77, 1'b0, 32'h0);
        tick();
        do_wb(4'd4, 32'h44, 1'b1, 32'h1000);
        expect_commit(4'd4, 5'd2, 32'h44);
        tick();
        idle();
        tick();
        check("t3_branch_commit", 64'(commit_valid), 64'(1));
        check("t3_branch_tag", 64'(commit_rob_num), 64'(4));
        check("t3_no_flush_yet", 64'(has_misbranch), 64'(0));
        check("t3_full_pending", 64'(rob_full), 64'(1));
        tick();
        check("t3_flush", 64'(has_misbranch), 64'(1));
        check("t3_redirect", 64'(redirect_pc), 64'(32'h1000));
        check("t3_no_commit_on_flush", 64'(commit_valid), 64'(0));
        check("t3_tail_reset", 64'(alloc_rob_num), 64'(0));
        check("t3_not_full", 64'(rob_full), 64'(0));
        tick();
        check("t3_flush_pulse", 64'(has_misbranch), 64'(0));
        tick();
        tick();
        check("t3_young_squashed", 64'(commit_valid), 64'(0));
        check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

        // Query bypass from the CDB versus stored result.
        for (int i = 0; i < 4; i++) begin
            do_alloc(5'(5 + i));
            tick();
        end
        idle();
        query1_rob_num = 4'd3;
        query2_rob_num = 4'd2;
        do_wb(4'd3, 32'hABCD, 1'b0, 32'h0);
        #1;
        check("t4_bypass_ready", 64'(query1_ready), 64'(1));
        check("t4_bypass_data", 64'(query1_data), 64'(32'hABCD));
        check("t4_unwritten_ready", 64'(query2_ready), 64'(0));
        check("t4_unwritten_data", 64'(query2_data), 64'(0));
        tick();
        idle();
        #1;
        check("t4_stored_ready", 64'(query1_ready), 64'(1));
        check("t4_stored_data", 64'(query1_data), 64'(32'hABCD));

        // rdy low freezes retirement and allocation.
        do_wb(4'd0, 32'h5A, 1'b0, 32'h0);
        expect_commit(4'd0, 5'd5, 32'h5A);
        tick();
        idle();
        rdy = 1'b0;
        do_alloc(5'd30);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_frozen_commit", 64'(commit_valid), 64'(0));
            check("t5_frozen_tail", 64'(alloc_rob_num), 64'(4));
        end
        rdy = 1'b1;
        idle();
        tick();
        check("t5_resume_commit", 64'(commit_valid), 64'(1));
        check("t5_resume_tag", 64'(commit_rob_num), 64'(0));
        check("t5_tail_held", 64'(alloc_rob_num), 64'(4));

        // Reset overrides a pending flush with six entries live.
        for (int i = 0; i < 4; i++) begin
            do_alloc(5'(9 + i));
            tick();
        end
        idle();
        do_wb(4'd1, 32'h11, 1'b1, 32'h2000);
        expect_commit(4'd1, 5'd6, 32'h11);
        tick();
        idle();
        tick();
        check("t6_branch_commit", 64'(commit_valid), 64'(1));
        check("t6_branch_tag", 64'(commit_rob_num), 64'(1));
        check("t6_pending", 64'(rob_full), 64'(1));
        rst = 1'b1;
        tick();
        check("t6_rst_commit_valid", 64'(commit_valid), 64'(0));
        check("t6_rst_has_misbranch", 64'(has_misbranch), 64'(0));
        check("t6_rst_redirect_pc", 64'(redirect_pc), 64'(0));
        check("t6_rst_commit_rd", 64'(commit_rd), 64'(0));
        check("t6_rst_commit_data", 64'(commit_data), 64'(0));
        check("t6_rst_commit_rob_num", 64'(commit_rob_num), 64'(0));
        check("t6_rst_rob_full", 64'(rob_full), 64'(0));
        check("t6_rst_alloc_rob_num", 64'(alloc_rob_num), 64'(0));
        rst = 1'b0;
        query1_rob_num = 4'd3;
        tick();
        check("t6_no_flush_after_rst", 64'(has_misbranch), 64'(0));
        check("t6_entries_cleared", 64'(query1_ready), 64'(0));
        tick();
        tick();
        check("t6_no_commit_after_rst", 64'(commit_valid), 64'(0));
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer between issue/CDB and the register file. It allocates a tag per issued instruction, captures results from the common data bus, and retires entries strictly in order. Each retirement drives the register file's commit port (valid, rd, data, tag). A mispredicted branch at the head causes a global flush after its own commit.

## Interface
- ROB_DEPTH, 16, number of entries (power of two)
- ROB_AW, 4, tag width, log2(ROB_DEPTH)
- DATA_W, 32, data/PC width

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; state frozen when low
- alloc_valid  in  1  issue requests an entry
- alloc_rd  in  5  destination register (0 = none)
- alloc_rob_num  out  ROB_AW  tag granted (= tail), combinational
- rob_full  out  1  no allocation accepted this cycle
- wb_valid  in  1  CDB broadcast
- wb_rob_num  in  ROB_AW  tag of finished instruction
- wb_data  in  DATA_W  result / link value
- wb_misbranch  in  1  instruction was mispredicted
- wb_target  in  DATA_W  correct PC if mispredicted
- query1_rob_num, query2_rob_num  in  ROB_AW  operand tags from issue
- query1_ready, query2_ready  out  1  tagged value available
- query1_data, query2_data  out  DATA_W  tagged value
- commit_valid  out  1  retire pulse (to register file has_from_rob)
- commit_rd  out  5  retired destination
- commit_data  out  DATA_W  retired value
- commit_rob_num  out  ROB_AW  retired tag
- has_misbranch  out  1  flush pulse to all consumers
- redirect_pc  out  DATA_W  fetch restart address, valid with has_misbranch

## Operation
- Per entry: valid, ready, rd, data, misbranch, target. Pointers head, tail (ROB_AW bits, wrap mod ROB_DEPTH); count 0..ROB_DEPTH.
- rob_full = (count == ROB_DEPTH) | flush_pending. Decision uses count before this edge; a same-cycle commit does not free a slot for a same-cycle allocation.
- Allocate (alloc_valid & ~rob_full): entry[tail] <= {valid=1, ready=0, rd, misbranch=0}; tail+1; count+1.
- Writeback (wb_valid, entry[wb_rob_num].valid): set ready, data, misbranch, target. Writeback to an invalid entry is ignored.
- Commit (entry[head].valid & ready & ~flush_pending): register commit_valid=1, commit_rd, commit_data, commit_rob_num=head. Clear entry, head+1, count-1. At most one commit per cycle. rd=0 still pulses; the register file discards it.
- Commit of a misbranch entry additionally sets flush_pending and latches redirect_pc=target.
- Flush edge (flush_pending): has_misbranch<=1; head=tail=count=0; all valid cleared; flush_pending<=0. The allocation, writeback, and commit of that cycle are discarded. has_misbranch is never in the same cycle as commit_valid, because the register file drops writes when has_misbranch is high.
- Query: queryN_ready = entry[tag].valid & ready, or a same-cycle wb_valid with wb_rob_num==tag (bypass; data from wb_data). Otherwise ready=0 and data=0.
- Simultaneous alloc + commit: count unchanged; both pointers advance.

## Timing
- Reset (edge with rst=1, regardless of rdy): head=tail=count=0, all entries invalid, flush_pending=0, commit_valid=0, commit_rd=0, commit_data=0, commit_rob_num=0, has_misbranch=0, redirect_pc=0. After reset, rob_full=0 and alloc_rob_num=0.
- rdy=0 at an edge: commit_valid and has_misbranch clear to 0; all other state is held.
- commit_valid and has_misbranch are one-cycle registered pulses.
- Latency: alloc at edge E, wb at E+1, commit outputs visible after E+2 (minimum). A writeback to the head commits on the following edge; there is no same-edge bypass.
- Misbranch: commit pulse after edge E, has_misbranch pulse after E+1; rob_full is high during the cycle between them.
- Wrap: tail 15 -> 0 and head 15 -> 0. Full and empty are distinguished by count, not by pointer equality.

## Test plan
- Reset, then 3 allocs (rd=1,2,3) and writebacks to tags 2,0,1 with data 0x22,0x00,0x11. Expect commits in order: tag0/rd1/0x00, tag1/rd2/0x11, tag2/rd3/0x22, one per cycle.
- Allocate 16 with no writeback. Expect rob_full=1 and a 17th alloc ignored (tail stays 0). Writeback and commit tag0, then allocate again: alloc_rob_num=0 is granted and count=16.
- Branch at tag4, wb_misbranch=1, wb_target=0x1000, with younger tags 5-7 ready. Expect commit of tag4, next cycle has_misbranch=1 and redirect_pc=0x1000, tags 5-7 never commit, then alloc_rob_num=0 and rob_full=0.
- Query tag3 in the same cycle as wb_valid to tag3 with 0xABCD. Expect query1_ready=1 and query1_data=0xABCD combinationally. Query an unwritten tag: expect ready=0.
- Hold rdy=0 for 5 cycles with head ready. Expect no commit_valid and pointers unchanged, then a commit on the first rdy=1 edge.
- Assert rst with 6 entries live and flush_pending set. Expect every output at its reset value next cycle and no has_misbranch pulse.
